fetch_align: RTL and testbench

Instruction fetch aligner sitting directly upstream of the compressed-instruction expander. It issues word-aligned fetches to instruction memory and buffers returned words as a halfword queue. It extracts one instruction per handshake (16-bit RVC or 32-bit, including 32-bit instructions straddling a word boundary) and presents it with its PC as `mem_instruction`-style data to the expander. It also handles PC redirects (branch/jump) by flushing and refetching.

---
 rtl/common_pkg.sv | 12 +
 rtl/fetch_hq.sv | 58 +++++
 rtl/fetch_align.sv | 115 +++++++++++
 tb/tb_fetch_align.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared fetch/decode widths and the RVC opcode helper.
package common;
   localparam int INSTRUCTION_WIDTH = 32;
   localparam int HALFWORD_WIDTH = 16;
   localparam int XLEN = 32;
   localparam logic [1:0] RVC_OPCODE_MASK = 2'b11;

   // A halfword whose two low bits are not both set starts a 16-bit instruction.
   function automatic logic is_compressed(input logic [HALFWORD_WIDTH-1:0] hw);
      return (hw[1:0] & RVC_OPCODE_MASK) != RVC_OPCODE_MASK;
   endfunction
endpackage

// File: rtl/fetch_hq.sv
// Halfword shift queue: entry 0 is the head, pops shift down, pushes append behind the survivors.
module fetch_hq
   import common::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [1:0]                push_cnt,
   input  logic [HALFWORD_WIDTH-1:0] push_lo,
   input  logic [HALFWORD_WIDTH-1:0] push_hi,
   input  logic [1:0]                pop_cnt,
   output logic [HALFWORD_WIDTH-1:0] head0,
   output logic [HALFWORD_WIDTH-1:0] head1,
   output logic [2:0]                count
);
   logic [HALFWORD_WIDTH-1:0] hq      [DEPTH];
   logic [HALFWORD_WIDTH-1:0] hq_next [DEPTH];
   logic [2:0]                count_next;
   logic [2:0]                base;

   // Shift out popped entries first, then drop new halfwords into the first free slots.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) hq_next[i] = hq[i];
      case (pop_cnt)
         2'd1: begin
            for (int i = 0; i < DEPTH - 1; i++) hq_next[i] = hq[i + 1];
            hq_next[DEPTH - 1] = '0;
         end
         2'd2: begin
            for (int i = 0; i < DEPTH - 2; i++) hq_next[i] = hq[i + 2];
            hq_next[DEPTH - 2] = '0;
            hq_next[DEPTH - 1] = '0;
         end
         default: ;
      endcase
      base = count - {1'b0, pop_cnt};
      for (int i = 0; i < DEPTH; i++) begin
         if (push_cnt != 2'd0 && 3'(i) == base) hq_next[i] = push_lo;
         if (push_cnt == 2'd2 && 3'(i) == base + 3'd1) hq_next[i] = push_hi;
      end
      count_next = base + {1'b0, push_cnt};
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) hq[i] <= '0;
      end else begin
         count <= count_next;
         for (int i = 0; i < DEPTH; i++) hq[i] <= hq_next[i];
      end
   end

   assign head0 = hq[0];
   assign head1 = hq[1];
endmodule

// File: rtl/fetch_align.sv
// Word fetcher + halfword aligner feeding the RVC expander; FETCH_ALIGN_RVC_EN enables 16-bit instructions.
module fetch_align
   import common::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         imem_req,
   output logic [XLEN-1:0]              imem_addr,
   input  logic                         imem_ready,
   input  logic                         imem_rvalid,
   input  logic [XLEN-1:0]              imem_rdata,
   input  logic                         redirect_valid,
   input  logic [XLEN-1:0]              redirect_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [INSTRUCTION_WIDTH-1:0] instr_data,
   output logic [XLEN-1:0]              instr_pc
);
`ifdef FETCH_ALIGN_RVC_EN
   localparam int  HQ_DEPTH = 4;
   localparam bit  RVC = 1'b1;
   localparam logic [XLEN-1:0] PC_MASK = ~32'h1;
`else
   localparam int  HQ_DEPTH = 2;
   localparam bit  RVC = 1'b0;
   localparam logic [XLEN-1:0] PC_MASK = ~32'h3;
`endif

   logic [XLEN-1:0]           fetch_addr;
   logic [XLEN-1:0]           pc;
   logic                      outstanding;
   logic                      drop_resp;
   logic                      skip_half;
   logic [HALFWORD_WIDTH-1:0] head0;
   logic [HALFWORD_WIDTH-1:0] head1;
   logic [2:0]                count;
   logic                      head_rvc;
   logic                      head_ready;
   logic                      room;
   logic                      accept;
   logic                      resp;
   logic                      push_ok;
   logic                      pop;
   logic [1:0]                push_cnt;
   logic [1:0]                pop_cnt;

`ifdef FETCH_ALIGN_RVC_EN
   assign head_rvc = is_compressed(head0);
   assign room     = count <= 3'd2;
`else
   assign head_rvc = 1'b0;
   assign room     = count == 3'd0;
`endif

   // A request is only issued when the queue can absorb the whole returning word.
   assign imem_req  = !rst && !outstanding && room && !redirect_valid;
   assign imem_addr = fetch_addr;
   assign accept    = imem_req && imem_ready;
   assign resp      = imem_rvalid && outstanding;
   assign push_ok   = resp && !drop_resp && !redirect_valid;
   assign push_cnt  = !push_ok ? 2'd0 : (skip_half ? 2'd1 : 2'd2);

   assign head_ready  = head_rvc ? (count >= 3'd1) : (count >= 3'd2);
   assign instr_valid = !rst && !redirect_valid && head_ready;
   assign pop         = instr_valid && instr_ready;
   assign pop_cnt     = !pop ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);
   assign instr_data  = head_rvc ? {16'h0000, head0} : {head1, head0};
   assign instr_pc    = pc;

   fetch_hq #(
      .DEPTH (HQ_DEPTH)
   ) u_hq (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push_cnt (push_cnt),
      .push_lo  (skip_half ? imem_rdata[31:16] : imem_rdata[15:0]),
      .push_hi  (imem_rdata[31:16]),
      .pop_cnt  (pop_cnt),
      .head0    (head0),
      .head1    (head1),
      .count    (count)
   );

   // A redirect keeps an in-flight request marked outstanding so its stale word can be swallowed.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_addr  <= {RESET_PC[31:2], 2'b00};
         pc          <= RESET_PC & PC_MASK;
         outstanding <= 1'b0;
         drop_resp   <= 1'b0;
         skip_half   <= RVC && RESET_PC[1];
      end else if (redirect_valid) begin
         fetch_addr  <= {redirect_pc[31:2], 2'b00};
         pc          <= redirect_pc & PC_MASK;
         outstanding <= outstanding && !imem_rvalid;
         drop_resp   <= outstanding && !imem_rvalid;
         skip_half   <= RVC && redirect_pc[1];
      end else begin
         if (accept) begin
            outstanding <= 1'b1;
            fetch_addr  <= fetch_addr + 32'd4;
         end else if (resp) begin
            outstanding <= 1'b0;
         end
         if (resp) begin
            drop_resp <= 1'b0;
            if (!drop_resp) skip_half <= 1'b0;
         end
         if (pop) pc <= pc + (head_rvc ? 32'd2 : 32'd4);
      end
   end
endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: a memory model, an instruction-stream reference model and a monitor.
module tb_fetch_align;
   import common::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   logic [31:0] mem [256];
   exp_t        exp_q [$];
   logic [31:0] model_pc = 32'h0;
   logic [31:0] exp_fetch = 32'h0;
   int          checks = 0;
   int          errors = 0;
   int          handshakes = 0;
   int          fixed_lat = 0;
   bit          ready_always = 1'b1;

   fetch_align #(
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_half(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: walk the memory image as an instruction stream from the current model pc.
   task automatic refill();
      logic [15:0] h;
      while (exp_q.size() < 32) begin
         if (RVC) begin
            h = mem_half(model_pc);
            if (h[1:0] != 2'b11) begin
               exp_q.push_back('{data: {16'h0000, h}, pc: model_pc});
               model_pc += 32'd2;
            end else begin
               exp_q.push_back('{data: {mem_half(model_pc + 32'd2), h}, pc: model_pc});
               model_pc += 32'd4;
            end
         end else begin
            exp_q.push_back('{data: mem[model_pc[9:2]], pc: model_pc});
            model_pc += 32'd4;
         end
      end
   endtask

   task automatic restart(input logic [31:0] p);
      exp_q.delete();
      model_pc  = RVC ? {p[31:1], 1'b0} : {p[31:2], 2'b00};
      exp_fetch = {p[31:2], 2'b00};
      refill();
   endtask

   task automatic fill_mem(input int mode);
      logic [15:0] lo, hi;
      for (int i = 0; i < 256; i++) begin
         lo = 16'($urandom);
         hi = 16'($urandom);
         if (mode == 0) begin
            lo = '0;
            hi = '0;
         end else if (mode == 2) begin
            lo[1:0] = 2'($urandom_range(0, 2));
            hi[1:0] = 2'($urandom_range(0, 2));
         end else begin
            lo[1:0] = $urandom_range(0, 1) != 0 ? 2'b11 : 2'($urandom_range(0, 2));
            hi[1:0] = $urandom_range(0, 1) != 0 ? 2'b11 : 2'($urandom_range(0, 2));
         end
         mem[i] = {hi, lo};
      end
   endtask

   task automatic apply_stimulus();
      @(posedge clk);
      #1;
      refill();
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      redirect_valid = 1'b0;
      restart(RESET_PC);
      repeat (cycles) apply_stimulus();
      check_output("reset_imem_req", {31'h0, imem_req}, 32'h0);
      check_output("reset_instr_valid", {31'h0, instr_valid}, 32'h0);
      rst = 1'b0;
      #1;
      check_output("post_reset_imem_req", {31'h0, imem_req}, 32'h1);
      check_output("post_reset_imem_addr", imem_addr, RESET_PC & ~32'h3);
      check_output("post_reset_instr_valid", {31'h0, instr_valid}, 32'h0);
      check_output("post_reset_instr_data", instr_data, 32'h0);
      check_output("post_reset_instr_pc", instr_pc, RESET_PC);
   endtask

   task automatic redirect_to(input logic [31:0] p);
      redirect_valid = 1'b1;
      redirect_pc = p;
      restart(p);
      apply_stimulus();
      redirect_valid = 1'b0;
   endtask

   task automatic run_until(input int n, input int budget, input string name);
      int start;
      int cyc;
      start = handshakes;
      cyc = 0;
      while (handshakes - start < n && cyc < budget) begin
         apply_stimulus();
         cyc++;
      end
      check_output(name, handshakes - start >= n ? 32'h1 : 32'h0, 32'h1);
   endtask

   // Memory model: captures handshakes mid-cycle, answers in order after a fixed or random delay.
   logic        hs_req = 1'b0;
   logic        hs_rsp = 1'b0;
   logic        hs_rst = 1'b1;
   logic [31:0] hs_addr = 32'h0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_wait = 0;

   always @(negedge clk) begin
      hs_req  = imem_req && imem_ready;
      hs_rsp  = imem_rvalid;
      hs_rst  = rst;
      hs_addr = imem_addr;
      if (hs_req) begin
         check_output("fetch_addr", imem_addr, exp_fetch);
         exp_fetch += 32'd4;
      end
   end

   always @(posedge clk) begin
      #1;
      if (hs_rst) begin
         pend = 1'b0;
      end else begin
         if (hs_rsp) pend = 1'b0;
         if (hs_req) begin
            pend = 1'b1;
            pend_addr = hs_addr;
            pend_wait = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 2));
         end
      end
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      if (pend) begin
         if (pend_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem[pend_addr[9:2]];
         end else begin
            pend_wait--;
         end
      end
      imem_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
   end

   // Monitor: whatever is presented must be the reference head; a handshake retires it.
   always @(negedge clk) begin
      if (instr_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL instr_unexpected: got pc %h, expected no instruction", instr_pc);
         end else begin
            check_output("instr_data", instr_data, exp_q[0].data);
            check_output("instr_pc", instr_pc, exp_q[0].pc);
            if (instr_ready) begin
               void'(exp_q.pop_front());
               handshakes++;
            end
         end
      end
   end

   initial begin
      bit seen;

      $display("[TB] fetch_align bench, RVC=%0d", RVC);
      fill_mem(0);
      mem[0] = 32'h0000_0013;
      instr_ready = 1'b1;
      do_reset(2);
      run_until(3, 60, "plain_word_stream");

      fill_mem(0);
      mem[0] = 32'h4505_4501;
      do_reset(1);
      run_until(4, 60, "compressed_pair");

      fill_mem(0);
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h4501_0000;
      do_reset(1);
      run_until(4, 60, "straddle");

      fill_mem(1);
      fixed_lat = 2;
      do_reset(1);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = imem_req && imem_ready;
      end
      check_output("redirect_found_request", {31'h0, seen}, 32'h1);
      @(posedge clk);
      #1;
      redirect_to(32'h0000_0102);
      run_until(6, 100, "redirect_stream");

      fill_mem(2);
      fixed_lat = 0;
      instr_ready = 1'b0;
      do_reset(1);
      repeat (10) apply_stimulus();
      check_output("stall_imem_req", {31'h0, imem_req}, 32'h0);
      check_output("stall_instr_valid", {31'h0, instr_valid}, 32'h1);
      instr_ready = 1'b1;
      run_until(8, 100, "stall_release");

      fill_mem(1);
      fixed_lat = -1;
      ready_always = 1'b0;
      do_reset(1);
      for (int i = 0; i < 600; i++) begin
         instr_ready = $urandom_range(0, 3) != 0;
         if (i == 300) begin
            do_reset(1);
         end else if ($urandom_range(0, 39) == 0) begin
            redirect_to({22'h0, 9'($urandom_range(0, 511)), 1'b0});
         end else begin
            apply_stimulus();
         end
      end
      instr_ready = 1'b1;
      run_until(20, 400, "random_tail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
